// File: rtl/csi2rx_pkt_decoder.sv
// CSI-2 single-lane packet decoder on the PPI byte stream: header capture with
// ECC correction, long-packet payload strobe, CRC-16 check and truncation detect.
module csi2rx_pkt_decoder (
    input  logic        rxbyteclkhs,
    input  logic        rxbyteclkhs_rst_n,
    input  logic        rxactivehs,
    input  logic        rxsynchs,
    input  logic        rxvalidhs,
    input  logic [7:0]  rxdatahs,
    output logic        pkt_hdr_valid,
    output logic [1:0]  virtual_channel,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic        short_pkt,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic        pkt_end,
    output logic        crc_err,
    output logic        ecc_corrected,
    output logic        ecc_uncorrectable,
    output logic        trunc_err
);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, DROP} state_t;

    // Header bit order on the wire: DI is D[7:0], WC LSB D[15:8], WC MSB D[23:16].
    typedef struct packed {
        logic [15:0] wc;
        logic [1:0]  vc;
        logic [5:0]  dt;
    } hdr_t;

    // Row p lists the data bits covered by parity bit P[p].
    localparam logic [5:0][23:0] PMASK = {
        24'hEFFC00, 24'hDF03F0, 24'hB8E38E,
        24'h749A6D, 24'hF2555B, 24'hF12CB7
    };

    state_t      state, state_nxt;
    logic [7:0]  di_q, wcl_q, wcm_q, crc_lsb_q;
    logic [1:0]  hdr_cnt;
    logic [15:0] rem_cnt;
    logic [15:0] crc_q;
    logic        crc_cnt;

    logic [23:0] hdr_raw, fix_mask;
    logic [5:0]  syndrome;
    logic        hdr_good, lost;
    hdr_t        hdr_fix;

    function automatic logic [5:0] ecc_parity(input logic [23:0] d);
        logic [5:0] p;
        for (int k = 0; k < 6; k++) p[k] = ^(d & PMASK[k]);
        return p;
    endfunction

    function automatic logic [23:0] syn_mask(input logic [5:0] syn);
        logic [23:0] m;
        m = '0;
        for (int i = 0; i < 24; i++)
            if (syn == {PMASK[5][i], PMASK[4][i], PMASK[3][i],
                        PMASK[2][i], PMASK[1][i], PMASK[0][i]})
                m[i] = 1'b1;
        return m;
    endfunction

    // Reflected CRC-16 (0x8408 is x^16+x^12+x^5+1 bit-reversed), LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    assign hdr_raw  = {wcm_q, wcl_q, di_q};
    assign syndrome = ecc_parity(hdr_raw) ^ rxdatahs[5:0];
    assign fix_mask = syn_mask(syndrome);
    assign hdr_fix  = hdr_t'(hdr_raw ^ fix_mask);
    assign hdr_good = (syndrome == 6'd0) || (|fix_mask) || $onehot(syndrome);
    assign lost     = !rxactivehs && (state == HDR || state == PAYLOAD || state == CRC);

    always_ff @(posedge rxbyteclkhs or negedge rxbyteclkhs_rst_n) begin
        if (!rxbyteclkhs_rst_n) state <= IDLE;
        else                    state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rxsynchs && rxvalidhs) state_nxt = HDR;
            HDR: begin
                if (lost) state_nxt = IDLE;
                else if (rxvalidhs && hdr_cnt == 2'd2) begin
                    if (!hdr_good)                   state_nxt = DROP;
                    else if (hdr_fix.dt[5:4] == 2'b00) state_nxt = DROP;
                    else if (hdr_fix.wc == 16'd0)    state_nxt = CRC;
                    else                             state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (lost) state_nxt = IDLE;
                else if (rxvalidhs && rem_cnt == 16'd1) state_nxt = CRC;
            end
            CRC: begin
                if (lost) state_nxt = IDLE;
                else if (rxvalidhs && crc_cnt) state_nxt = DROP;
            end
            DROP:    if (!rxactivehs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rxbyteclkhs or negedge rxbyteclkhs_rst_n) begin
        if (!rxbyteclkhs_rst_n) begin
            pkt_hdr_valid     <= 1'b0;
            virtual_channel   <= 2'd0;
            data_type         <= 6'd0;
            word_count        <= 16'd0;
            short_pkt         <= 1'b0;
            payload_valid     <= 1'b0;
            payload_data      <= 8'h00;
            pkt_end           <= 1'b0;
            crc_err           <= 1'b0;
            ecc_corrected     <= 1'b0;
            ecc_uncorrectable <= 1'b0;
            trunc_err         <= 1'b0;
            di_q              <= 8'h00;
            wcl_q             <= 8'h00;
            wcm_q             <= 8'h00;
            crc_lsb_q         <= 8'h00;
            hdr_cnt           <= 2'd0;
            rem_cnt           <= 16'd0;
            crc_q             <= 16'hFFFF;
            crc_cnt           <= 1'b0;
        end else begin
            pkt_hdr_valid     <= 1'b0;
            payload_valid     <= 1'b0;
            pkt_end           <= 1'b0;
            crc_err           <= 1'b0;
            ecc_corrected     <= 1'b0;
            ecc_uncorrectable <= 1'b0;
            trunc_err         <= 1'b0;
            if (lost) begin
                trunc_err <= 1'b1;
            end else if (rxvalidhs) begin
                case (state)
                    IDLE: if (rxsynchs) begin
                        di_q    <= rxdatahs;
                        hdr_cnt <= 2'd0;
                    end
                    HDR: begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_cnt == 2'd0)      wcl_q <= rxdatahs;
                        else if (hdr_cnt == 2'd1) wcm_q <= rxdatahs;
                        else if (hdr_good) begin
                            pkt_hdr_valid   <= 1'b1;
                            virtual_channel <= hdr_fix.vc;
                            data_type       <= hdr_fix.dt;
                            word_count      <= hdr_fix.wc;
                            short_pkt       <= (hdr_fix.dt[5:4] == 2'b00);
                            ecc_corrected   <= (syndrome != 6'd0);
                            rem_cnt         <= hdr_fix.wc;
                            crc_q           <= 16'hFFFF;
                            crc_cnt         <= 1'b0;
                        end else begin
                            ecc_uncorrectable <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        payload_valid <= 1'b1;
                        payload_data  <= rxdatahs;
                        rem_cnt       <= rem_cnt - 16'd1;
                        crc_q         <= crc_byte(crc_q, rxdatahs);
                    end
                    CRC: begin
                        if (!crc_cnt) begin
                            crc_lsb_q <= rxdatahs;
                            crc_cnt   <= 1'b1;
                        end else begin
                            pkt_end <= 1'b1;
                            crc_err <= (crc_q != {rxdatahs, crc_lsb_q});
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csi2rx_pkt_decoder.sv
// Directed bench for csi2rx_pkt_decoder: inputs driven on the falling edge,
// outputs checked on a later falling edge.
module tb_csi2rx_pkt_decoder;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        act = 1'b0, sync = 1'b0, vld = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        pkt_hdr_valid, short_pkt, payload_valid, pkt_end, crc_err;
    logic        ecc_corrected, ecc_uncorrectable, trunc_err;
    logic [1:0]  virtual_channel;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic [7:0]  payload_data;

    always #5 clk = ~clk;

    csi2rx_pkt_decoder dut (
        .rxbyteclkhs(clk), .rxbyteclkhs_rst_n(rst_n),
        .rxactivehs(act), .rxsynchs(sync), .rxvalidhs(vld), .rxdatahs(data),
        .pkt_hdr_valid(pkt_hdr_valid), .virtual_channel(virtual_channel),
        .data_type(data_type), .word_count(word_count), .short_pkt(short_pkt),
        .payload_valid(payload_valid), .payload_data(payload_data),
        .pkt_end(pkt_end), .crc_err(crc_err), .ecc_corrected(ecc_corrected),
        .ecc_uncorrectable(ecc_uncorrectable), .trunc_err(trunc_err)
    );

    int vectors = 0, miscompares = 0;
    int pay_n = 0, end_n = 0, hdr_n = 0;
    logic [7:0] seen [0:511];
    logic [7:0] pl [0:23] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                              8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                              8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    always @(negedge clk) begin
        if (payload_valid) begin
            seen[pay_n[8:0]] = payload_data;
            pay_n = pay_n + 1;
        end
        if (pkt_end)       end_n = end_n + 1;
        if (pkt_hdr_valid) hdr_n = hdr_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic s);
        @(negedge clk);
        act = 1'b1; vld = 1'b1; sync = s; data = b;
    endtask

    task automatic stall();
        @(negedge clk);
        act = 1'b1; vld = 1'b0; sync = 1'b0; data = 8'hA5;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            act = 1'b0; vld = 1'b0; sync = 1'b0;
        end
    endtask

    task automatic hdr(input logic [7:0] di, input logic [7:0] wcl,
                       input logic [7:0] wcm, input logic [7:0] ecc);
        put(di, 1'b1); put(wcl, 1'b0); put(wcm, 1'b0); put(ecc, 1'b0);
    endtask

    // With gaps, every byte is followed by an idle cycle and byte 5 carries a stray sync.
    task automatic payload(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            put(pl[i], gaps && i == 5);
            if (gaps) stall();
        end
    endtask

    task automatic check_payload(input int base, input string tag);
        for (int i = 0; i < 24; i++) chk(tag, seen[base + i], pl[i]);
    endtask

    initial begin
        int b_pay, b_end, b_hdr;

        quiet(3);
        chk("rst_pulses", {pkt_hdr_valid, payload_valid, pkt_end, crc_err, ecc_corrected,
                           ecc_uncorrectable, trunc_err, short_pkt}, 0);
        chk("rst_fields", {virtual_channel, data_type, word_count}, 0);
        chk("rst_pdata", payload_data, 0);
        chk("rst_state", dut.state, 0);
        chk("rst_crc", dut.crc_q, 16'hFFFF);
        rst_n = 1'b1;
        quiet(2);

        // Short packet: DI=00 WC=0001 ECC=1A
        b_pay = pay_n; b_end = end_n; b_hdr = hdr_n;
        hdr(8'h00, 8'h01, 8'h00, 8'h1A);
        chk("short_hv_early", pkt_hdr_valid, 0);
        stall();
        chk("short_hv", pkt_hdr_valid, 1);
        chk("short_fields", {virtual_channel, data_type, word_count}, 24'h000001);
        chk("short_flag", short_pkt, 1);
        chk("short_ecc", {ecc_corrected, ecc_uncorrectable}, 0);
        put(8'h33, 1'b1); put(8'h44, 1'b0);
        quiet(3);
        chk("short_nopay", pay_n - b_pay, 0);
        chk("short_noend", end_n - b_end, 0);
        chk("short_hcnt", hdr_n - b_hdr, 1);

        // Long packet DI=12 WC=24 ECC=1B, good CRC
        b_pay = pay_n; b_end = end_n;
        hdr(8'h12, 8'h18, 8'h00, 8'h1B);
        stall();
        chk("long_hv", pkt_hdr_valid, 1);
        chk("long_fields", {virtual_channel, data_type, word_count}, 24'h120018);
        chk("long_flag", short_pkt, 0);
        payload(24, 0);
        put(8'hF0, 1'b0); put(8'h00, 1'b0);
        stall();
        chk("long_end", pkt_end, 1);
        chk("long_crc", crc_err, 0);
        quiet(3);
        chk("long_npay", pay_n - b_pay, 24);
        chk("long_nend", end_n - b_end, 1);
        check_payload(b_pay, "long_byte");

        // Corrupted CRC
        b_end = end_n;
        hdr(8'h12, 8'h18, 8'h00, 8'h1B);
        stall();
        payload(24, 0);
        put(8'hF1, 1'b0); put(8'h00, 1'b0);
        stall();
        chk("badcrc_end", pkt_end, 1);
        chk("badcrc_err", crc_err, 1);
        stall();
        chk("badcrc_pulse", {pkt_end, crc_err}, 0);
        quiet(3);
        chk("badcrc_nend", end_n - b_end, 1);

        // WC bit 3 flipped: corrected back to 0x0018
        b_pay = pay_n;
        hdr(8'h12, 8'h10, 8'h00, 8'h1B);
        stall();
        chk("corr_flag", {ecc_corrected, ecc_uncorrectable}, 2'b10);
        chk("corr_hv", pkt_hdr_valid, 1);
        chk("corr_wc", word_count, 16'h0018);
        stall();
        chk("corr_pulse", ecc_corrected, 0);
        payload(24, 0);
        put(8'hF0, 1'b0); put(8'h00, 1'b0);
        stall();
        chk("corr_end", {pkt_end, crc_err}, 2'b10);
        quiet(3);
        chk("corr_npay", pay_n - b_pay, 24);

        // Two WC bits flipped: uncorrectable, packet dropped
        b_pay = pay_n; b_end = end_n; b_hdr = hdr_n;
        hdr(8'h12, 8'h00, 8'h00, 8'h1B);
        stall();
        chk("unc_flag", {ecc_corrected, ecc_uncorrectable}, 2'b01);
        chk("unc_hv", pkt_hdr_valid, 0);
        payload(24, 0);
        put(8'hF0, 1'b0); put(8'h00, 1'b0);
        stall();
        quiet(3);
        chk("unc_npay", pay_n - b_pay, 0);
        chk("unc_nend", end_n - b_end, 0);
        chk("unc_nhdr", hdr_n - b_hdr, 0);

        // Long packet with WC=0: straight to CRC, seed value expected
        b_pay = pay_n;
        hdr(8'h12, 8'h00, 8'h00, 8'h18);
        stall();
        chk("wc0_hv", pkt_hdr_valid, 1);
        chk("wc0_wc", word_count, 0);
        put(8'hFF, 1'b0); put(8'hFF, 1'b0);
        stall();
        chk("wc0_end", {pkt_end, crc_err}, 2'b10);
        quiet(3);
        chk("wc0_npay", pay_n - b_pay, 0);

        // Payload with rxvalidhs low every other cycle and a stray sync
        b_pay = pay_n;
        hdr(8'h12, 8'h18, 8'h00, 8'h1B);
        stall();
        payload(24, 1);
        put(8'hF0, 1'b0); stall(); put(8'h00, 1'b0);
        stall();
        chk("gap_end", {pkt_end, crc_err}, 2'b10);
        quiet(3);
        chk("gap_npay", pay_n - b_pay, 24);
        check_payload(b_pay, "gap_byte");

        // Burst ends after 5 of 24 payload bytes
        b_pay = pay_n; b_end = end_n;
        hdr(8'h12, 8'h18, 8'h00, 8'h1B);
        stall();
        payload(5, 0);
        quiet(1);
        quiet(1);
        chk("trunc_flag", trunc_err, 1);
        chk("trunc_state", dut.state, 0);
        quiet(3);
        chk("trunc_pulse", trunc_err, 0);
        chk("trunc_nend", end_n - b_end, 0);
        chk("trunc_npay", pay_n - b_pay, 5);

        // Reset in the middle of a payload: rest of burst must be ignored
        hdr(8'h12, 8'h18, 8'h00, 8'h1B);
        stall();
        payload(3, 0);
        @(negedge clk);
        rst_n = 1'b0; vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b_pay = pay_n; b_end = end_n; b_hdr = hdr_n;
        payload(24, 0);
        put(8'hF0, 1'b0); put(8'h00, 1'b0);
        stall();
        quiet(3);
        chk("rstmid_npay", pay_n - b_pay, 0);
        chk("rstmid_nend", end_n - b_end, 0);
        chk("rstmid_nhdr", hdr_n - b_hdr, 0);
        chk("rstmid_state", dut.state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
